ddr_local_if_mem: RTL



---
 rtl/ddr_local_if_pkg.sv | 15 +
 rtl/ddr_local_if_bram.sv | 21 ++
 rtl/ddr_local_if_mem.sv | 110 +++++++++++
 3 files changed

// File: rtl/ddr_local_if_pkg.sv
// ddr_local_if_pkg: shared types and constants for the DDR local-interface memory responder.
package ddr_local_if_pkg;
   localparam int LOCAL_AW     = 23;
   localparam int LOCAL_DW     = 32;
   localparam int LOCAL_SIZE_W = 7;
   localparam int MAX_BURST    = 64;

   typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_WRITE, ST_READ} state_t;

   // Zero-length bursts act as single beats; oversize requests are held to the burst limit.
   function automatic logic [LOCAL_SIZE_W-1:0] burst_len(input logic [LOCAL_SIZE_W-1:0] s);
      return (s == '0) ? LOCAL_SIZE_W'(1) :
             (s > LOCAL_SIZE_W'(MAX_BURST)) ? LOCAL_SIZE_W'(MAX_BURST) : s;
   endfunction
endpackage

// File: rtl/ddr_local_if_bram.sv
// ddr_local_if_bram: single-port byte-enabled RAM with one-cycle registered read.
module ddr_local_if_bram
   import ddr_local_if_pkg::*;
#(
   parameter int AW = 12
) (
   input  logic                i_clk,
   input  logic                i_we,
   input  logic [3:0]          i_be,
   input  logic [AW-1:0]       i_addr,
   input  logic [LOCAL_DW-1:0] i_wdata,
   output logic [LOCAL_DW-1:0] o_rdata
);
   logic [LOCAL_DW-1:0] r_mem [2**AW];

   always_ff @(posedge i_clk) begin
      for (int b = 0; b < 4; b++)
         if (i_we && i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      o_rdata <= r_mem[i_addr];
   end
endmodule

// File: rtl/ddr_local_if_mem.sv
// ddr_local_if_mem: on-chip RAM responder emulating the Altera DDR controller local interface.
module ddr_local_if_mem
   import ddr_local_if_pkg::*;
#(
   parameter int MEM_AW      = 12,
   parameter int RD_LATENCY  = 4,
   parameter int INIT_CYCLES = 16
) (
   input  logic                    local_clk_i,
   input  logic                    local_reset_n_i,
   input  logic [LOCAL_AW-1:0]     local_address_i,
   input  logic                    local_write_req_i,
   input  logic                    local_read_req_i,
   input  logic                    local_burstbegin_i,
   input  logic [LOCAL_DW-1:0]     local_wdata_i,
   input  logic [3:0]              local_be_i,
   input  logic [LOCAL_SIZE_W-1:0] local_size_i,
   output logic                    local_ready_o,
   output logic [LOCAL_DW-1:0]     local_rdata_o,
   output logic                    local_rdata_valid_o,
   output logic                    local_init_done_o
);
   localparam int IW   = $clog2(INIT_CYCLES + 1);
   localparam int VP_W = RD_LATENCY - 1;
   localparam logic [VP_W-1:0] VP_LAST = VP_W'(1) << (RD_LATENCY - 2);

   state_t                  r_state, w_next;
   logic [IW-1:0]           r_icnt;
   logic                    r_init_done;
   logic [MEM_AW-1:0]       r_addr;
   logic [LOCAL_SIZE_W-1:0] r_rem;
   logic [VP_W-1:0]         r_vp;
   logic [LOCAL_SIZE_W-1:0] w_size;
   logic                    w_we, w_issue, w_wacc_burst, w_start;
   logic [MEM_AW-1:0]       w_maddr, w_in_addr;
   logic [LOCAL_DW-1:0]     w_q, w_dout;
   logic                    w_unused;

   assign w_unused     = ^{local_burstbegin_i, local_address_i[LOCAL_AW-1:MEM_AW]};
   assign w_size       = burst_len(local_size_i);
   assign w_in_addr    = local_address_i[MEM_AW-1:0];
   assign w_start      = (r_state == ST_IDLE) && (local_write_req_i || local_read_req_i);
   assign w_wacc_burst = (r_state == ST_WRITE) && local_write_req_i;
   assign w_we         = ((r_state == ST_IDLE) && local_write_req_i) || w_wacc_burst;
   assign w_issue      = (r_state == ST_READ) && (r_rem != '0);
   assign w_maddr      = (r_state == ST_IDLE) ? w_in_addr : r_addr;

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_INIT:  if (r_icnt == IW'(INIT_CYCLES - 1)) w_next = ST_IDLE;
         ST_IDLE:  w_next = local_write_req_i ? ((w_size == LOCAL_SIZE_W'(1)) ? ST_IDLE : ST_WRITE) :
                            local_read_req_i  ? ST_READ : ST_IDLE;
         ST_WRITE: if (local_write_req_i && (r_rem == LOCAL_SIZE_W'(1))) w_next = ST_IDLE;
         ST_READ:  if ((r_rem == '0) && (r_vp == VP_LAST)) w_next = ST_IDLE;
         default:  w_next = ST_INIT;
      endcase
   end

   always_ff @(posedge local_clk_i or negedge local_reset_n_i) begin
      if (!local_reset_n_i) begin
         r_state     <= ST_INIT;
         r_icnt      <= '0;
         r_init_done <= 1'b0;
         r_addr      <= '0;
         r_rem       <= '0;
         r_vp        <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == ST_INIT) r_icnt <= r_icnt + 1'b1;
         if ((r_state == ST_INIT) && (w_next == ST_IDLE)) r_init_done <= 1'b1;
         // A write in IDLE has already consumed beat 0, so the burst resumes one word on.
         if (w_start) begin
            r_addr <= local_write_req_i ? w_in_addr + 1'b1 : w_in_addr;
            r_rem  <= local_write_req_i ? w_size - 1'b1 : w_size;
         end else if (w_wacc_burst || w_issue) begin
            r_addr <= r_addr + 1'b1;
            r_rem  <= r_rem - 1'b1;
         end
         r_vp[0] <= w_issue;
         for (int i = 1; i < VP_W; i++) r_vp[i] <= r_vp[i-1];
      end
   end

   ddr_local_if_bram #(.AW(MEM_AW)) u_bram (
      .i_clk   (local_clk_i),
      .i_we    (w_we),
      .i_be    (local_be_i),
      .i_addr  (w_maddr),
      .i_wdata (local_wdata_i),
      .o_rdata (w_q)
   );

   // The RAM supplies one cycle of latency; the rest is made up here.
   if (RD_LATENCY == 2) begin : g_nodly
      assign w_dout = w_q;
   end else begin : g_dly
      logic [LOCAL_DW-1:0] r_dp [RD_LATENCY-2];
      always_ff @(posedge local_clk_i) begin
         r_dp[0] <= w_q;
         for (int i = 1; i < RD_LATENCY - 2; i++) r_dp[i] <= r_dp[i-1];
      end
      assign w_dout = r_dp[RD_LATENCY-3];
   end

   assign local_ready_o       = (r_state == ST_IDLE) || (r_state == ST_WRITE);
   assign local_rdata_valid_o = r_vp[VP_W-1];
   assign local_rdata_o       = r_vp[VP_W-1] ? w_dout : '0;
   assign local_init_done_o   = r_init_done;
endmodule
